ex_stage_pipe: RTL and testbench
================================

Name: ex_stage_pipe

Overview:
Registered, parametrised execute stage that replaces the purely combinational EX datapath. It accepts one operation per cycle over a valid/ready handshake and performs the same operand selection as today: A is RS or RD, B is IMM or RS, and the comparator always uses RD against B. Results, compare flags and overflow are registered toward MEM. Multiplication and division run multi-cycle when the optional feature is compiled in.

Parameters:
- CPU_WIDTH, 16: datapath width; legal range 8..32.
- OP_W, 4: ALU opcode width; must be at least 4.

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- rst_n, input, 1: synchronous active-low reset.
- flush, input, 1: kill in-flight and held operation.
- in_valid, input, 1: operation presented.
- in_ready, output, 1: stage accepts operation this cycle.
- RD, input, CPU_WIDTH: destination-register operand.
- RS, input, CPU_WIDTH: source-register operand.
- IMM, input, CPU_WIDTH: immediate.
- ABSel, input, 1: 1 selects A=RS, 0 selects A=RD.
- IMMop, input, 1: 1 selects B=IMM, 0 selects B=RS; the same B feeds the comparator.
- ALUop, input, OP_W: operation code.
- out_valid, output, 1: result registers valid.
- out_ready, input, 1: downstream consumes the result.
- ALUout, output, CPU_WIDTH: result.
- CMPout, output, 2: [1] = RD<B signed; [0] = RD==B.
- overflow, output, 1: signed overflow, ADD/SUB only, otherwise 0.
- busy, output, 1: multi-cycle operation in progress.

Behaviour:
- Reset (rst_n=0 at a clock edge): out_valid=0, ALUout=0, CMPout=0, overflow=0, busy=0, state=IDLE.
- Reset mid-divide abandons the operation; no output is produced.
- States:
  - IDLE: no result held.
  - HOLD: out_valid=1, waiting for out_ready.
  - BUSY: multi-cycle operation iterating.
- Ready rule: in_ready = !busy && (!out_valid || out_ready).
- Accept = in_valid && in_ready.
- Single-cycle ops: result registered on the accept edge, so latency is 1.
  - out_valid rises the cycle after accept.
  - Back-to-back accepts with out_ready held at 1 give one result per cycle.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount is B[$clog2(CPU_WIDTH)-1:0].
  - 8 MUL: low CPU_WIDTH bits of the product.
  - 9 DIVU: unsigned quotient.
  - 10 REMU: unsigned remainder.
  - 11 to 15: ALUout=0, flags computed normally.
- Arithmetic: wraps modulo 2^CPU_WIDTH.
- overflow: set when the operand signs are compatible and the result sign differs (ADD: same signs; SUB: opposite signs).
- CMPout: computed from the accepted operands and registered in the same cycle as ALUout, including for multi-cycle ops.
- Multi-cycle (opcodes 8..10, feature on):
  - Accept moves IDLE/HOLD to BUSY; busy=1 and in_ready=0.
  - CPU_WIDTH iteration cycles, then the result is written and the state moves to HOLD.
  - Total latency: CPU_WIDTH+1 cycles from accept to out_valid.
- Divide by zero: quotient = all ones; remainder = dividend. Latency unchanged.
- Holding: while out_valid && !out_ready, all outputs stay stable; in_ready=0 unless out_ready.
- Simultaneous out_ready and accept: the old result retires and the new one loads in the same edge.
- Flush:
  - Synchronous; out_valid=0, busy=0, state=IDLE next cycle.
  - Flush overrides a same-cycle accept, so that operation is dropped.
  - ALUout keeps its last value (don't-care).
- in_valid without in_ready: ignored; the upstream stage must hold its operands.

Optional Feature:
- Macro: EX_MULDIV_EN.
- Defined:
  - ex_muldiv_iter is instantiated.
  - Opcodes 8..10 follow the multi-cycle rules above.
- Undefined:
  - No iterative unit and no BUSY state; busy is tied to 0.
  - Opcodes 8..10 behave as 11..15: single-cycle, ALUout=0.

Decomposition:
- Shared para.v defines:
  - Opcode constants ALU_ADD..ALU_REMU.
  - State encodings EX_IDLE, EX_HOLD, EX_BUSY.
  - CMP bit indices CMP_LT and CMP_EQ.
- One natural sub-module, ex_muldiv_iter:
  - Shift-add multiplier plus restoring divider sharing one CPU_WIDTH-bit counter.
  - Interface: start, op, a, b, done, result.
  - done is a 1-cycle pulse.
- ALU and CMP logic stay inline as combinational functions.

Test Plan:
1. Reset:
   - Drive rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, busy=0, ALUout=0.
   - Release rst_n -> in_ready=1.
2. ADD with IMM, CPU_WIDTH=16:
   - RD=0x7FFF, IMM=0x0001, ABSel=0, IMMop=1, ALUop=ADD.
   - Next cycle -> ALUout=0x8000, overflow=1, CMPout=2'b00.
3. Backpressure:
   - Issue SUB RD=5, RS=5 with out_ready=0 -> ALUout=0, CMPout=2'b01 held for 3 cycles, in_ready=0.
   - Raise out_ready with an AND op queued -> both results retire back-to-back.
4. DIVU (EX_MULDIV_EN):
   - RD=100, RS=7, ABSel=0, IMMop=0 -> busy for 16 cycles; out_valid at cycle 17 with ALUout=14.
   - Same operands with REMU -> ALUout=2.
5. Divide by zero:
   - DIVU with RS=0 -> ALUout=0xFFFF.
   - REMU with RS=0 -> ALUout=RD.
6. Flush:
   - Assert flush 4 cycles into a MUL -> next cycle busy=0, out_valid=0, in_ready=1.
   - Issue a new ADD 3+4 -> ALUout=7 one cycle later.

Source files
------------

// File: rtl/ex_stage_pipe_pkg.sv
// rtl/ex_stage_pipe_pkg.sv - shared opcodes, state encodings and flag helpers for the EX stage
package ex_stage_pipe_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_MUL  = 4'd8;
    localparam logic [3:0] ALU_DIVU = 4'd9;
    localparam logic [3:0] ALU_REMU = 4'd10;

    localparam logic [1:0] EX_IDLE = 2'd0;
    localparam logic [1:0] EX_HOLD = 2'd1;
    localparam logic [1:0] EX_BUSY = 2'd2;

    localparam int CMP_LT = 1;
    localparam int CMP_EQ = 0;

    // Iterative unit operation codes: the low two bits of ALU_MUL..ALU_REMU
    localparam logic [1:0] MD_MUL  = 2'd0;
    localparam logic [1:0] MD_DIVU = 2'd1;
    localparam logic [1:0] MD_REMU = 2'd2;

    // Signed overflow from operand and result sign bits
    function automatic logic sign_overflow(input logic a_msb, input logic b_msb,
                                           input logic r_msb, input logic is_sub);
        if (is_sub)
            return (a_msb != b_msb) && (r_msb != a_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/ex_stage_pipe_muldiv_iter.sv
// rtl/ex_stage_pipe_muldiv_iter.sv - shift-add multiplier and restoring divider sharing one counter
module ex_muldiv_iter #(
    parameter int CPU_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [CPU_WIDTH-1:0] a,
    input  logic [CPU_WIDTH-1:0] b,
    output logic                 done,
    output logic [CPU_WIDTH-1:0] result
);
    import ex_stage_pipe_pkg::*;

    localparam int N  = CPU_WIDTH;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(N);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // x: product accumulator or partial remainder; y: shifted multiplicand or
    // dividend/quotient; z: shifted multiplier or divisor
    logic [N:0]    x, x_nxt, rem_sh;
    logic [N-1:0]  y, y_nxt, z, z_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    op_r;
    logic          running;

    // One multiply or divide step from the current register contents
    always_comb begin
        x_nxt  = x;
        y_nxt  = y;
        z_nxt  = z;
        rem_sh = {x[N-1:0], y[N-1]};
        if (op_r == MD_MUL) begin
            x_nxt = {1'b0, x[N-1:0] + (z[0] ? y : {N{1'b0}})};
            y_nxt = {y[N-2:0], 1'b0};
            z_nxt = {1'b0, z[N-1:1]};
        end else if (rem_sh >= {1'b0, z}) begin
            x_nxt = rem_sh - {1'b0, z};
            y_nxt = {y[N-2:0], 1'b1};
        end else begin
            x_nxt = rem_sh;
            y_nxt = {y[N-2:0], 1'b0};
        end
    end

    // Load on start (restarting any abandoned run), iterate N times, pulse done with the result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x       <= '0;
            y       <= '0;
            z       <= '0;
            cnt     <= '0;
            op_r    <= MD_MUL;
            running <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                x       <= '0;
                y       <= a;
                z       <= b;
                op_r    <= op;
                cnt     <= CNT_INIT;
                running <= 1'b1;
            end else if (running) begin
                x   <= x_nxt;
                y   <= y_nxt;
                z   <= z_nxt;
                cnt <= cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                    result  <= (op_r == MD_DIVU) ? y_nxt : x_nxt[N-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/ex_stage_pipe.sv
// rtl/ex_stage_pipe.sv - registered EX stage with valid/ready handshake; EX_MULDIV_EN adds iterative MUL/DIVU/REMU
module ex_stage_pipe #(
    parameter int CPU_WIDTH = 16,
    parameter int OP_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CPU_WIDTH-1:0] RD,
    input  logic [CPU_WIDTH-1:0] RS,
    input  logic [CPU_WIDTH-1:0] IMM,
    input  logic                 ABSel,
    input  logic                 IMMop,
    input  logic [OP_W-1:0]      ALUop,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CPU_WIDTH-1:0] ALUout,
    output logic [1:0]           CMPout,
    output logic                 overflow,
    output logic                 busy
);
    import ex_stage_pipe_pkg::*;

    localparam int SH_W = $clog2(CPU_WIDTH);

    logic [1:0]           state;
    logic [1:0]           cmp_pend;
    logic [CPU_WIDTH-1:0] op_a, op_b, alu_res, md_result;
    logic [1:0]           cmp_res;
    logic                 ovf_res, accept, is_md, md_done;

    // Single-cycle ALU; codes without a single-cycle meaning yield zero
    function automatic logic [CPU_WIDTH-1:0] alu_f(input logic [OP_W-1:0] op,
                                                   input logic [CPU_WIDTH-1:0] a,
                                                   input logic [CPU_WIDTH-1:0] b);
        case (op)
            OP_W'(ALU_ADD): return a + b;
            OP_W'(ALU_SUB): return a - b;
            OP_W'(ALU_AND): return a & b;
            OP_W'(ALU_OR):  return a | b;
            OP_W'(ALU_XOR): return a ^ b;
            OP_W'(ALU_SLL): return a << b[SH_W-1:0];
            OP_W'(ALU_SRL): return a >> b[SH_W-1:0];
            OP_W'(ALU_SRA): return $signed(a) >>> b[SH_W-1:0];
            default:        return '0;
        endcase
    endfunction

    // Comparator always looks at RD against the selected B operand
    function automatic logic [1:0] cmp_f(input logic [CPU_WIDTH-1:0] rd,
                                         input logic [CPU_WIDTH-1:0] b);
        logic [1:0] c;
        c         = 2'b00;
        c[CMP_LT] = $signed(rd) < $signed(b);
        c[CMP_EQ] = (rd == b);
        return c;
    endfunction

    assign op_a      = ABSel ? RS : RD;
    assign op_b      = IMMop ? IMM : RS;
    assign alu_res   = alu_f(ALUop, op_a, op_b);
    assign cmp_res   = cmp_f(RD, op_b);
    assign ovf_res   = (ALUop == OP_W'(ALU_ADD)) ? sign_overflow(op_a[CPU_WIDTH-1], op_b[CPU_WIDTH-1], alu_res[CPU_WIDTH-1], 1'b0) :
                       (ALUop == OP_W'(ALU_SUB)) ? sign_overflow(op_a[CPU_WIDTH-1], op_b[CPU_WIDTH-1], alu_res[CPU_WIDTH-1], 1'b1) :
                       1'b0;

    assign out_valid = (state == EX_HOLD);
    assign busy      = (state == EX_BUSY);
    assign in_ready  = !busy && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

`ifdef EX_MULDIV_EN
    logic md_start;

    assign is_md    = (ALUop == OP_W'(ALU_MUL)) || (ALUop == OP_W'(ALU_DIVU)) || (ALUop == OP_W'(ALU_REMU));
    assign md_start = accept && is_md && !flush;

    ex_muldiv_iter #(
        .CPU_WIDTH(CPU_WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .op     (ALUop[1:0]),
        .a      (op_a),
        .b      (op_b),
        .done   (md_done),
        .result (md_result)
    );
`else
    assign is_md     = 1'b0;
    assign md_done   = 1'b0;
    assign md_result = '0;
`endif

    // Stage control: flush wins, then accept (which also retires any held result), then completion/retire.
    // A done pulse outside BUSY belongs to a flushed operation and is ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EX_IDLE;
            ALUout   <= '0;
            CMPout   <= 2'b00;
            overflow <= 1'b0;
            cmp_pend <= 2'b00;
        end else if (flush) begin
            state <= EX_IDLE;
        end else if (accept && is_md) begin
            state    <= EX_BUSY;
            cmp_pend <= cmp_res;
        end else if (accept) begin
            state    <= EX_HOLD;
            ALUout   <= alu_res;
            CMPout   <= cmp_res;
            overflow <= ovf_res;
        end else if (busy && md_done) begin
            state    <= EX_HOLD;
            ALUout   <= md_result;
            CMPout   <= cmp_pend;
            overflow <= 1'b0;
        end else if (out_valid && out_ready) begin
            state <= EX_IDLE;
        end
    end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb/tb_ex_stage_pipe.sv - directed self-checking bench for ex_stage_pipe (EX_MULDIV_EN-aware)
module tb_ex_stage_pipe;
    import ex_stage_pipe_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n, flush, in_valid, in_ready, ABSel, IMMop;
    logic [W-1:0] RD, RS, IMM, ALUout;
    logic [3:0]   ALUop;
    logic         out_valid, out_ready, overflow, busy;
    logic [1:0]   CMPout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] rd, rs, imm;
        logic         absel, immop;
        logic [W-1:0] res;
        logic [1:0]   cmp;
        logic         ovf;
    } vec_t;

    vec_t vecs[$];

    ex_stage_pipe #(.CPU_WIDTH(W), .OP_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .RD        (RD),
        .RS        (RS),
        .IMM       (IMM),
        .ABSel     (ABSel),
        .IMMop     (IMMop),
        .ALUop     (ALUop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUout    (ALUout),
        .CMPout    (CMPout),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] rd, input logic [W-1:0] rs,
                         input logic [W-1:0] imm, input logic absel, input logic immop);
        ALUop    = op;
        RD       = rd;
        RS       = rs;
        IMM      = imm;
        ABSel    = absel;
        IMMop    = immop;
        in_valid = 1'b1;
    endtask

`ifdef EX_MULDIV_EN
    task automatic run_md(input string tag, input logic [3:0] op, input logic [W-1:0] rd,
                          input logic [W-1:0] rs, input logic [W-1:0] exp, input logic [1:0] exp_cmp);
        drive(op, rd, rs, '0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        repeat (W) tick();
        check({tag, "_early"}, out_valid, 1'b0);
        tick();
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_res"}, ALUout, exp);
        check({tag, "_cmp"}, CMPout, exp_cmp);
        check({tag, "_ovf"}, overflow, 1'b0);
        tick();
    endtask
`endif

    initial begin
        bit seen;
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(ALU_ADD, 16'h0001, 16'h0001, 16'h0001, 1'b0, 1'b0);

        // reset held two cycles with in_valid high
        tick();
        tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_aluout", ALUout, 16'h0000);
        check("rst_cmp", CMPout, 2'b00);
        check("rst_ovf", overflow, 1'b0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);

        // ADD with immediate overflowing into the sign bit
        drive(ALU_ADD, 16'h7FFF, 16'h0000, 16'h0001, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        check("add_valid", out_valid, 1'b1);
        check("add_res", ALUout, 16'h8000);
        check("add_ovf", overflow, 1'b1);
        check("add_cmp", CMPout, 2'b00);
        tick();
        check("add_retired", out_valid, 1'b0);

        // backpressure: SUB held three cycles while an AND waits
        out_ready = 1'b0;
        drive(ALU_SUB, 16'd5, 16'd5, 16'h0000, 1'b0, 1'b0);
        tick();
        drive(ALU_AND, 16'h00F0, 16'h0FF0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_res", ALUout, 16'h0000);
            check("hold_cmp", CMPout, 2'b01);
            check("hold_in_ready", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("retire_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check("and_valid", out_valid, 1'b1);
        check("and_res", ALUout, 16'h00F0);
        check("and_cmp", CMPout, 2'b10);
        tick();
        check("and_retired", out_valid, 1'b0);

        // back-to-back single-cycle table with out_ready held high
        vecs.push_back('{ALU_SUB, 16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b0, 16'h7FFF, 2'b10, 1'b1});
        vecs.push_back('{ALU_OR,  16'h00F0, 16'h0F00, 16'h00F0, 1'b1, 1'b1, 16'h0FF0, 2'b01, 1'b0});
        vecs.push_back('{ALU_XOR, 16'hFFFF, 16'h00FF, 16'h0000, 1'b0, 1'b0, 16'hFF00, 2'b10, 1'b0});
        vecs.push_back('{ALU_SLL, 16'h0001, 16'h0000, 16'h0013, 1'b0, 1'b1, 16'h0008, 2'b10, 1'b0});
        vecs.push_back('{ALU_SRL, 16'h8000, 16'h0000, 16'h0004, 1'b0, 1'b1, 16'h0800, 2'b10, 1'b0});
        vecs.push_back('{ALU_SRA, 16'h8000, 16'h0000, 16'h0004, 1'b0, 1'b1, 16'hF800, 2'b10, 1'b0});
        vecs.push_back('{ALU_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'b10, 1'b0});
        vecs.push_back('{4'd13,   16'h0003, 16'h0003, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'b01, 1'b0});
`ifndef EX_MULDIV_EN
        vecs.push_back('{ALU_MUL, 16'h0003, 16'h0004, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'b10, 1'b0});
`endif
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm, vecs[i].absel, vecs[i].immop);
            tick();
            check($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            check($sformatf("vec%0d_res", i), ALUout, vecs[i].res);
            check($sformatf("vec%0d_cmp", i), CMPout, vecs[i].cmp);
            check($sformatf("vec%0d_ovf", i), overflow, vecs[i].ovf);
            check($sformatf("vec%0d_busy", i), busy, 1'b0);
        end
        in_valid = 1'b0;
        tick();

        // flush overrides a same-cycle accept
        drive(ALU_ADD, 16'd1, 16'd1, 16'h0000, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_drop", out_valid, 1'b0);

`ifdef EX_MULDIV_EN
        run_md("divu", ALU_DIVU, 16'd100, 16'd7, 16'd14, 2'b00);
        run_md("remu", ALU_REMU, 16'd100, 16'd7, 16'd2, 2'b00);
        run_md("divz", ALU_DIVU, 16'h1234, 16'h0000, 16'hFFFF, 2'b00);
        run_md("remz", ALU_REMU, 16'h1234, 16'h0000, 16'h1234, 2'b00);
        run_md("mul",  ALU_MUL,  16'h0045, 16'h0123, 16'h4E6F, 2'b10);
        run_md("mulw", ALU_MUL,  16'h1234, 16'h0100, 16'h3400, 2'b00);

        // flush four cycles into a MUL
        drive(ALU_MUL, 16'd3, 16'd5, 16'h0000, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("mflush_busy", busy, 1'b0);
        check("mflush_valid", out_valid, 1'b0);
        check("mflush_in_ready", in_ready, 1'b1);
`endif

        // new op after flush
        drive(ALU_ADD, 16'd3, 16'd4, 16'h0000, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("post_flush_valid", out_valid, 1'b1);
        check("post_flush_res", ALUout, 16'd7);
        tick();
        seen = 1'b0;
        repeat (24) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        check("no_stale_result", seen, 1'b0);

`ifdef EX_MULDIV_EN
        // reset mid-divide abandons the operation
        drive(ALU_DIVU, 16'd100, 16'd7, 16'h0000, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rstdiv_busy", busy, 1'b0);
        check("rstdiv_valid", out_valid, 1'b0);
        seen = 1'b0;
        repeat (24) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        check("rstdiv_no_result", seen, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
